// File: rtl/sram_arbiter.sv
// -----------------------------------------------------------------------------
// sram_arbiter
//
// Shares the single request port of the SRAM controller between N requesters
// (for example the SPI debug bridge and the pattern tester). One transaction
// is outstanding downstream at a time. Completion and read data are routed
// back to the requester that owns the transaction. A watchdog aborts any
// transaction that the controller never completes.
//
// Ports
//   clk             system clock (100 MHz domain)
//   reset_l         asynchronous assert, active-low reset
//   m_req[N]        per-requester request level
//   m_rh_wl[N]      per-requester direction (1 = read, 0 = write)
//   m_addr[N*AW]    packed addresses, requester i at [i*AW +: AW]
//   m_data_w[N*DW]  packed write data, requester i at [i*DW +: DW]
//   m_ack[N]        one-cycle completion pulse to the owner
//   m_err[N]        one-cycle abort pulse, coincident with m_ack
//   m_data_r[DW]    read data, valid while the owner's m_ack is high
//   sram_req/addr/rh_wl/data_w   registered request to the controller
//   sram_ack        controller acceptance/completion pulse
//   sram_data_r     controller read data
//   sram_data_r_en  read-data-valid pulse (same cycle as or after sram_ack)
//   grant[N]        one-hot current owner, 0 when idle
//   busy            high whenever the arbiter is not idle
// -----------------------------------------------------------------------------
module sram_arbiter #(
    parameter int N   = 2,
    parameter int AW  = 19,
    parameter int DW  = 8,
    parameter int TMO = 255
) (
    input  logic            clk,
    input  logic            reset_l,
    input  logic [N-1:0]    m_req,
    input  logic [N-1:0]    m_rh_wl,
    input  logic [N*AW-1:0] m_addr,
    input  logic [N*DW-1:0] m_data_w,
    output logic [N-1:0]    m_ack,
    output logic [N-1:0]    m_err,
    output logic [DW-1:0]   m_data_r,
    output logic            sram_req,
    output logic [AW-1:0]   sram_addr,
    output logic            sram_rh_wl,
    output logic [DW-1:0]   sram_data_w,
    input  logic            sram_ack,
    input  logic [DW-1:0]   sram_data_r,
    input  logic            sram_data_r_en,
    output logic [N-1:0]    grant,
    output logic            busy
);

    localparam int             IW    = (N > 2) ? 2 : 1;
    localparam logic [IW:0]    N_W   = (IW+1)'(N);
    localparam logic [7:0]     TMO_W = 8'(TMO);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        RDWAIT = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t          state_reg,     state_next;
    logic [IW-1:0]   last_reg,      last_next;
    logic [IW-1:0]   owner_reg,     owner_next;
    logic [N-1:0]    grant_reg,     grant_next;
    logic            sram_req_reg,  sram_req_next;
    logic [AW-1:0]   sram_addr_reg, sram_addr_next;
    logic            sram_rh_wl_reg, sram_rh_wl_next;
    logic [DW-1:0]   sram_data_w_reg, sram_data_w_next;
    logic [DW-1:0]   data_r_reg,    data_r_next;
    logic            err_reg,       err_next;
    logic [7:0]      cnt_reg,       cnt_next;

    // Per-requester views of the packed operand buses.
    logic [AW-1:0] addr_arr  [N];
    logic [DW-1:0] wdata_arr [N];

    for (genvar gi = 0; gi < N; gi++) begin : g_unpack
        assign addr_arr[gi]  = m_addr[gi*AW +: AW];
        assign wdata_arr[gi] = m_data_w[gi*DW +: DW];
    end

    // Round-robin pick: first set request scanning upward from last+1.
    // The loop walks offsets from far to near so the nearest candidate is
    // the final assignment and therefore wins.
    logic          pick_valid;
    logic [IW-1:0] pick_idx;
    logic [IW:0]   scan_sum;
    logic [IW-1:0] scan_cand;

    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        scan_sum   = '0;
        scan_cand  = '0;
        for (int off = N; off >= 1; off--) begin
            scan_sum = {1'b0, last_reg} + (IW+1)'(off);
            if (scan_sum >= N_W) begin
                scan_sum = scan_sum - N_W;
            end
            scan_cand = scan_sum[IW-1:0];
            if (m_req[scan_cand]) begin
                pick_valid = 1'b1;
                pick_idx   = scan_cand;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_reg       <= IDLE;
            last_reg        <= IW'(N - 1);
            owner_reg       <= '0;
            grant_reg       <= '0;
            sram_req_reg    <= 1'b0;
            sram_addr_reg   <= '0;
            sram_rh_wl_reg  <= 1'b0;
            sram_data_w_reg <= '0;
            data_r_reg      <= '0;
            err_reg         <= 1'b0;
            cnt_reg         <= '0;
        end else begin
            state_reg       <= state_next;
            last_reg        <= last_next;
            owner_reg       <= owner_next;
            grant_reg       <= grant_next;
            sram_req_reg    <= sram_req_next;
            sram_addr_reg   <= sram_addr_next;
            sram_rh_wl_reg  <= sram_rh_wl_next;
            sram_data_w_reg <= sram_data_w_next;
            data_r_reg      <= data_r_next;
            err_reg         <= err_next;
            cnt_reg         <= cnt_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        last_next        = last_reg;
        owner_next       = owner_reg;
        grant_next       = grant_reg;
        sram_req_next    = sram_req_reg;
        sram_addr_next   = sram_addr_reg;
        sram_rh_wl_next  = sram_rh_wl_reg;
        sram_data_w_next = sram_data_w_reg;
        data_r_next      = data_r_reg;
        err_next         = err_reg;
        cnt_next         = cnt_reg;

        case (state_reg)
            IDLE: begin
                if (pick_valid) begin
                    owner_next           = pick_idx;
                    grant_next           = '0;
                    grant_next[pick_idx] = 1'b1;
                    sram_addr_next       = addr_arr[pick_idx];
                    sram_rh_wl_next      = m_rh_wl[pick_idx];
                    sram_data_w_next     = wdata_arr[pick_idx];
                    sram_req_next        = 1'b1;
                    // Cleared here so an aborted read returns zero data.
                    data_r_next          = '0;
                    err_next             = 1'b0;
                    cnt_next             = '0;
                    state_next           = ISSUE;
                end
            end

            ISSUE: begin
                cnt_next = cnt_reg + 8'd1;
                // A real acknowledge takes priority over a coincident timeout.
                if (sram_ack) begin
                    sram_req_next = 1'b0;
                    if (!sram_rh_wl_reg) begin
                        state_next = DONE;
                    end else if (sram_data_r_en) begin
                        data_r_next = sram_data_r;
                        state_next  = DONE;
                    end else begin
                        state_next = RDWAIT;
                    end
                end else if (cnt_reg == TMO_W) begin
                    sram_req_next = 1'b0;
                    err_next      = 1'b1;
                    state_next    = DONE;
                end
            end

            RDWAIT: begin
                cnt_next = cnt_reg + 8'd1;
                if (sram_data_r_en) begin
                    data_r_next = sram_data_r;
                    state_next  = DONE;
                end else if (cnt_reg == TMO_W) begin
                    err_next   = 1'b1;
                    state_next = DONE;
                end
            end

            DONE: begin
                last_next  = owner_reg;
                grant_next = '0;
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Completion is a pure decode of DONE, so it lasts exactly one cycle.
    assign m_ack       = (state_reg == DONE) ? grant_reg : '0;
    assign m_err       = err_reg ? m_ack : '0;
    assign m_data_r    = data_r_reg;
    assign sram_req    = sram_req_reg;
    assign sram_addr   = sram_addr_reg;
    assign sram_rh_wl  = sram_rh_wl_reg;
    assign sram_data_w = sram_data_w_reg;
    assign grant       = grant_reg;
    assign busy        = (state_reg != IDLE);

endmodule
